// File: rtl/sysid_boot_checker.sv
//------------------------------------------------------------------------------
// Module   : sysid_boot_checker
// Brief    : Avalon-MM master that reads the system ID and timestamp words and
//            checks them against build-time expected values.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1563116811,
    parameter int unsigned START_DELAY        = 16,
    parameter int unsigned TIMEOUT            = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] id_value,
    output logic [31:0] timestamp_value,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_RD_ID = 2'd1,
        S_RD_TS = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] c_start_delay = 16'(START_DELAY);
    localparam logic [15:0] c_timeout_m1  = 16'(TIMEOUT - 1);
    localparam bit          c_timeout_en  = (TIMEOUT != 0);

    state_t      state_q, state_d;
    logic [15:0] delay_q, delay_d;
    logic [15:0] stall_q, stall_d;
    logic        address_q, address_d;
    logic        read_q, read_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic        w_abort;

    // The current stall cycle is the TIMEOUT-th one: abort instead of counting.
    assign w_abort = c_timeout_en && avm_waitrequest && (stall_q == c_timeout_m1);

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        stall_d    = stall_q;
        address_d  = address_q;
        read_d     = read_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        done_d     = done_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_WAIT: begin
                if (delay_q == 16'd0) begin
                    state_d   = S_RD_ID;
                    read_d    = 1'b1;
                    address_d = 1'b0;
                    stall_d   = 16'd0;
                end else begin
                    delay_d = delay_q - 16'd1;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (!avm_waitrequest) begin
                    stall_d = 16'd0;
                    if (state_q == S_RD_ID) begin
                        id_value_d = avm_readdata;
                        state_d    = S_RD_TS;
                        address_d  = 1'b1;
                    end else begin
                        ts_value_d = avm_readdata;
                        state_d    = S_DONE;
                        read_d     = 1'b0;
                        done_d     = 1'b1;
                        id_ok_d    = (id_value_q == EXPECTED_ID);
                        ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
                    end
                end else if (w_abort) begin
                    state_d   = S_DONE;
                    read_d    = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d   = S_RD_ID;
                    read_d    = 1'b1;
                    address_d = 1'b0;
                    stall_d   = 16'd0;
                    done_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = S_WAIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_WAIT;
            delay_q    <= c_start_delay;
            stall_q    <= 16'd0;
            address_q  <= 1'b0;
            read_q     <= 1'b0;
            id_value_q <= 32'd0;
            ts_value_q <= 32'd0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            stall_q    <= stall_d;
            address_q  <= address_d;
            read_q     <= read_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            timeout_q  <= timeout_d;
        end
    end

    assign avm_address     = address_q;
    assign avm_read        = read_q;
    assign id_value        = id_value_q;
    assign timestamp_value = ts_value_q;
    assign done            = done_q;
    assign id_ok           = id_ok_q;
    assign ts_ok           = ts_ok_q;
    assign timeout         = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
//------------------------------------------------------------------------------
// Module   : tb_sysid_boot_checker
// Brief    : Self-checking bench for sysid_boot_checker with a stalling slave.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sysid_boot_checker;

    localparam logic [31:0] c_ts_good = 32'd1563116811;

    logic        clk = 1'b0;
    logic        rst_a = 1'b0;
    logic        rst_b = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;

    logic        address_a, read_a, wr_a, done_a, id_ok_a, ts_ok_a, timeout_a;
    logic [31:0] rdata_a, id_value_a, ts_value_a;
    logic        address_b, read_b, done_b, id_ok_b, ts_ok_b, timeout_b;
    logic [31:0] rdata_b, id_value_b, ts_value_b;

    logic [31:0] id_data = 32'd0;
    logic [31:0] ts_data = 32'd0;
    int          stall_id = 0;
    int          stall_ts = 0;
    int          xfers;
    int          stalls;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sysid_boot_checker #(
        .START_DELAY (16),
        .TIMEOUT     (8)
    ) dut_a (
        .clock           (clk),
        .reset_n         (rst_a),
        .start           (start_a),
        .avm_address     (address_a),
        .avm_read        (read_a),
        .avm_waitrequest (wr_a),
        .avm_readdata    (rdata_a),
        .id_value        (id_value_a),
        .timestamp_value (ts_value_a),
        .done            (done_a),
        .id_ok           (id_ok_a),
        .ts_ok           (ts_ok_a),
        .timeout         (timeout_a)
    );

    sysid_boot_checker #(
        .START_DELAY (0)
    ) dut_b (
        .clock           (clk),
        .reset_n         (rst_b),
        .start           (start_b),
        .avm_address     (address_b),
        .avm_read        (read_b),
        .avm_waitrequest (1'b0),
        .avm_readdata    (rdata_b),
        .id_value        (id_value_b),
        .timestamp_value (ts_value_b),
        .done            (done_b),
        .id_ok           (id_ok_b),
        .ts_ok           (ts_ok_b),
        .timeout         (timeout_b)
    );

    // Slave A: stalls the first transfer of a burst stall_id cycles, the second stall_ts.
    assign wr_a    = read_a && ((xfers == 0 && stalls < stall_id) || (xfers == 1 && stalls < stall_ts));
    assign rdata_a = address_a ? ts_data : id_data;
    assign rdata_b = address_b ? c_ts_good : 32'd0;

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            xfers  <= 0;
            stalls <= 0;
        end else if (read_a) begin
            if (wr_a) begin
                stalls <= stalls + 1;
            end else begin
                stalls <= 0;
                xfers  <= xfers + 1;
            end
        end else begin
            xfers  <= 0;
            stalls <= 0;
        end
    end

    typedef struct {
        logic [31:0] id_d;
        logic [31:0] ts_d;
        int          s_id;
        int          s_ts;
        int          done_edge;
        int          rd_cyc;
        logic        id_ok;
        logic        ts_ok;
        logic        to;
        logic [31:0] id_val;
        logic [31:0] ts_val;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(logic [31:0] i, logic [31:0] t, int si, int st, int de, int rc,
                                logic io, logic tso, logic to, logic [31:0] iv, logic [31:0] tv);
        vec_t v;
        v.id_d = i;  v.ts_d = t;  v.s_id = si;  v.s_ts = st;
        v.done_edge = de;  v.rd_cyc = rc;
        v.id_ok = io;  v.ts_ok = tso;  v.to = to;  v.id_val = iv;  v.ts_val = tv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps edges until done; edge_n stays 0 if the bound expires.
    task automatic run_edges(output int edge_n, output int rd_cyc, output int addr_err);
        edge_n = 0; rd_cyc = 0; addr_err = 0;
        for (int e = 1; e <= 200; e++) begin
            tick();
            if (read_a) begin
                rd_cyc++;
                if (xfers == 0 && address_a !== 1'b0) addr_err++;
                if (xfers == 1 && address_a !== 1'b1) addr_err++;
            end
            if (done_a) begin
                edge_n = e;
                break;
            end
        end
    endtask

    task automatic pulse_start_a();
        @(negedge clk);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    function automatic logic [31:0] outs_a();
        return {22'd0, address_a, read_a, done_a, id_ok_a, ts_ok_a, timeout_a,
                |id_value_a, |ts_value_a, 2'b00};
    endfunction

    int edge_n, rd_cyc, addr_err;

    initial begin
        vecs[0] = mk(32'd0,         c_ts_good,        0,    0,    19, 2, 1, 1, 0, 32'd0,         c_ts_good);
        vecs[1] = mk(32'd0,         c_ts_good + 1,    0,    0,    19, 2, 1, 0, 0, 32'd0,         c_ts_good + 1);
        vecs[2] = mk(32'hDEAD_BEEF, c_ts_good,        0,    0,    19, 2, 0, 1, 0, 32'hDEAD_BEEF, c_ts_good);
        vecs[3] = mk(32'd0,         c_ts_good,        5,    0,    24, 7, 1, 1, 0, 32'd0,         c_ts_good);
        vecs[4] = mk(32'd0,         c_ts_good,        7,    0,    26, 9, 1, 1, 0, 32'd0,         c_ts_good);
        vecs[5] = mk(32'd0,         c_ts_good,        0,    2,    21, 4, 1, 1, 0, 32'd0,         c_ts_good);
        vecs[6] = mk(32'd0,         c_ts_good,        1000, 0,    25, 8, 0, 0, 1, 32'd0,         32'd0);
        vecs[7] = mk(32'h1234_5678, c_ts_good,        0,    1000, 26, 9, 0, 0, 1, 32'h1234_5678, 32'd0);
        vecs[8] = mk(32'd0,         c_ts_good,        8,    0,    25, 8, 0, 0, 1, 32'd0,         32'd0);

        // No-delay instance: read after edge 1, done after edge 3.
        @(negedge clk);
        chk("b_reset_outs", {30'd0, read_b, done_b}, 32'd0);
        rst_b = 1'b1;
        tick();
        chk("b_read_edge1", {31'd0, read_b}, 32'd1);
        tick();
        chk("b_done_edge2", {31'd0, done_b}, 32'd0);
        tick();
        chk("b_done_edge3", {28'd0, done_b, id_ok_b, ts_ok_b, timeout_b}, 32'b1110);
        chk("b_ts_value", ts_value_b, c_ts_good);

        for (int i = 0; i < 9; i++) begin
            id_data  = vecs[i].id_d;
            ts_data  = vecs[i].ts_d;
            stall_id = vecs[i].s_id;
            stall_ts = vecs[i].s_ts;
            @(negedge clk);
            rst_a = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_reset_outs", i), outs_a(), 32'd0);
            rst_a = 1'b1;
            run_edges(edge_n, rd_cyc, addr_err);
            chk($sformatf("v%0d_done_edge", i), edge_n, vecs[i].done_edge);
            chk($sformatf("v%0d_read_cycles", i), rd_cyc, vecs[i].rd_cyc);
            chk($sformatf("v%0d_addr_hold", i), addr_err, 0);
            chk($sformatf("v%0d_id_ok", i), {31'd0, id_ok_a}, {31'd0, vecs[i].id_ok});
            chk($sformatf("v%0d_ts_ok", i), {31'd0, ts_ok_a}, {31'd0, vecs[i].ts_ok});
            chk($sformatf("v%0d_timeout", i), {31'd0, timeout_a}, {31'd0, vecs[i].to});
            chk($sformatf("v%0d_id_value", i), id_value_a, vecs[i].id_val);
            chk($sformatf("v%0d_ts_value", i), ts_value_a, vecs[i].ts_val);
        end

        // Restart from a timed-out DONE with a healthy slave.
        id_data = 32'd0; ts_data = c_ts_good; stall_id = 0; stall_ts = 0;
        tick();
        chk("done_holds", {30'd0, done_a, timeout_a}, 32'b11);
        pulse_start_a();
        chk("restart_clear", {28'd0, done_a, timeout_a, read_a, address_a}, 32'b0010);
        tick();
        chk("restart_edge1", {31'd0, done_a}, 32'd0);
        tick();
        chk("restart_edge2", {28'd0, done_a, id_ok_a, ts_ok_a, timeout_a}, 32'b1110);

        // Start during a stalled RD_TS is dropped, not queued.
        stall_ts = 3;
        pulse_start_a();
        tick();
        pulse_start_a();
        chk("rdts_start_ignored", {30'd0, done_a, read_a}, 32'b01);
        tick(); tick();
        chk("rdts_still_busy", {31'd0, done_a}, 32'd0);
        tick();
        chk("rdts_done", {29'd0, done_a, id_ok_a, ts_ok_a}, 32'b111);
        tick();
        chk("start_not_queued", {30'd0, done_a, read_a}, 32'b10);

        // Asynchronous reset during RD_TS.
        pulse_start_a();
        tick();
        #2 rst_a = 1'b0;
        #1;
        chk("async_reset_outs", outs_a(), 32'd0);
        stall_ts = 0;
        @(negedge clk);
        rst_a = 1'b1;
        run_edges(edge_n, rd_cyc, addr_err);
        chk("after_reset_done_edge", edge_n, 19);
        chk("after_reset_flags", {29'd0, id_ok_a, ts_ok_a, timeout_a}, 32'b110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
